// File: rtl/button_event_if.sv
// ---------------------------------------------------------------------------
// button_event_if
// Bundles the debounced level input of one button with the event outputs that
// button_event derives from it.
//   level          debounced button level, 1 = pressed
//   press_pulse    one-cycle pulse on press
//   short_pulse    one-cycle pulse on release before the long-press point
//   long_pulse     one-cycle pulse when the hold reaches the long-press point
//   repeat_pulse   one-cycle auto-repeat pulse while held past long press
//   release_pulse  one-cycle pulse on any release
//   held           registered copy of level
// master: the environment side (drives level, consumes events).
// slave : the button_event side (consumes level, drives events).
// ---------------------------------------------------------------------------
interface button_event_if;
    logic level;
    logic press_pulse;
    logic short_pulse;
    logic long_pulse;
    logic repeat_pulse;
    logic release_pulse;
    logic held;

    modport master (
        output level,
        input  press_pulse,
        input  short_pulse,
        input  long_pulse,
        input  repeat_pulse,
        input  release_pulse,
        input  held
    );

    modport slave (
        input  level,
        output press_pulse,
        output short_pulse,
        output long_pulse,
        output repeat_pulse,
        output release_pulse,
        output held
    );
endinterface

// File: rtl/button_event.sv
// ---------------------------------------------------------------------------
// button_event
// Turns one debounced button level into single-cycle UI events: press,
// short release, long press, auto-repeat and release. All outputs are
// registered.
// Parameters:
//   LONG_CYCLES    hold length (cycles) that counts as a long press, >= 2
//   REPEAT_CYCLES  spacing of auto-repeat pulses after long press, >= 1
//   REPEAT_EN      1 = emit auto-repeat pulses while held past long press
//   CNT_W          hold-counter width, 2^CNT_W > max(LONG, REPEAT)
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  button_event_if slave side (level in, events and held out)
// ---------------------------------------------------------------------------
module button_event #(
    parameter int LONG_CYCLES   = 2000,
    parameter int REPEAT_CYCLES = 250,
    parameter bit REPEAT_EN     = 1'b1,
    parameter int CNT_W         = 16
) (
    input  logic            clk,
    input  logic            rst,
    button_event_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             level_q_r;

    logic             press_r,   press_nxt_s;
    logic             short_r,   short_nxt_s;
    logic             long_r,    long_nxt_s;
    logic             repeat_r,  repeat_nxt_s;
    logic             release_r, release_nxt_s;

    logic             rise_s;
    logic             fall_s;

    // Edge detect against the previous sampled level.
    always_comb begin
        rise_s = bus.level & ~level_q_r;
        fall_s = ~bus.level & level_q_r;
    end

    // Next-state, hold counter and event decode. A release on the same edge
    // as the long/repeat point wins, so no long/repeat pulse is emitted then.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        press_nxt_s   = 1'b0;
        short_nxt_s   = 1'b0;
        long_nxt_s    = 1'b0;
        repeat_nxt_s  = 1'b0;
        release_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rise_s) begin
                    state_nxt_s = ST_PRESSED;
                    cnt_nxt_s   = CNT_ONE;
                    press_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s   = CNT_ZERO;
                end
            end
            ST_PRESSED: begin
                if (fall_s) begin
                    state_nxt_s   = ST_IDLE;
                    short_nxt_s   = 1'b1;
                    release_nxt_s = 1'b1;
                    cnt_nxt_s     = CNT_ZERO;
                end else if (cnt_r == LONG_LAST) begin
                    state_nxt_s   = ST_LONG;
                    long_nxt_s    = 1'b1;
                    cnt_nxt_s     = CNT_ZERO;
                end else begin
                    cnt_nxt_s     = cnt_r + CNT_ONE;
                end
            end
            ST_LONG: begin
                if (fall_s) begin
                    state_nxt_s   = ST_IDLE;
                    release_nxt_s = 1'b1;
                    cnt_nxt_s     = CNT_ZERO;
                end else if (REPEAT_EN && (cnt_r == REPEAT_LAST)) begin
                    repeat_nxt_s  = 1'b1;
                    cnt_nxt_s     = CNT_ZERO;
                end else if (REPEAT_EN) begin
                    cnt_nxt_s     = cnt_r + CNT_ONE;
                end else begin
                    // Without auto-repeat the counter has nothing to time.
                    cnt_nxt_s     = CNT_ZERO;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, counter, level history and registered event outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            level_q_r <= 1'b0;
            press_r   <= 1'b0;
            short_r   <= 1'b0;
            long_r    <= 1'b0;
            repeat_r  <= 1'b0;
            release_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            level_q_r <= bus.level;
            press_r   <= press_nxt_s;
            short_r   <= short_nxt_s;
            long_r    <= long_nxt_s;
            repeat_r  <= repeat_nxt_s;
            release_r <= release_nxt_s;
        end
    end

    assign bus.press_pulse   = press_r;
    assign bus.short_pulse   = short_r;
    assign bus.long_pulse    = long_r;
    assign bus.repeat_pulse  = repeat_r;
    assign bus.release_pulse = release_r;
    assign bus.held          = level_q_r;

endmodule

// File: doc/button_event.md
# button_event

Converts one debounced button level into discrete single-cycle user-interface events for the alarm-clock controller: press, short release, long press, auto-repeat and release. It sits downstream of the per-button debounce stage and upstream of the time/alarm setting logic, so that the setting FSMs consume clean events instead of raw levels.

## Interface
- LONG_CYCLES, default 2000: clk cycles a press must be held to count as a long press; legal range ≥ 2.
- REPEAT_CYCLES, default 250: clk cycles between auto-repeat pulses once long press is reached; legal range ≥ 1.
- REPEAT_EN, default 1: 1 = emit auto-repeat pulses in LONG state; 0 = no repeats.
- CNT_W, default 16: hold-counter width; must satisfy 2^CNT_W > max(LONG_CYCLES, REPEAT_CYCLES).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- level  in  1  debounced button level, 1 = pressed; synchronous to clk.
- press_pulse  out  1  one-cycle pulse on press (rising edge of level).
- short_pulse  out  1  one-cycle pulse on release before long press was reached.
- long_pulse  out  1  one-cycle pulse once when hold reaches LONG_CYCLES.
- repeat_pulse  out  1  one-cycle pulse every REPEAT_CYCLES while held past long press.
- release_pulse  out  1  one-cycle pulse on any release (falling edge of level).
- held  out  1  registered copy of level (level_q).

## Operation
- Registers: level_q, state, cnt[CNT_W-1:0], five pulse outputs. All outputs registered.
- Reset: state = IDLE, cnt = 0, level_q = 0, all outputs 0 (held = 0).
- Edge detect at each clock edge: rise = level & ~level_q; fall = ~level & level_q. level_q <= level every edge.
- States: IDLE, PRESSED, LONG.
- IDLE: on rise -> PRESSED, cnt <= 1, press_pulse <= 1. Otherwise stay, cnt held at 0.
- PRESSED: on fall -> IDLE, short_pulse <= 1, release_pulse <= 1, cnt <= 0. Else if cnt == LONG_CYCLES-1 -> LONG, long_pulse <= 1, cnt <= 0. Else cnt <= cnt+1.
- LONG: on fall -> IDLE, release_pulse <= 1 (no short_pulse), cnt <= 0. Else if REPEAT_EN and cnt == REPEAT_CYCLES-1 -> repeat_pulse <= 1, cnt <= 0. Else cnt <= cnt+1 (REPEAT_EN=0: cnt frozen at 0).
- Pulse outputs default to 0 every edge unless set above; each is exactly one cycle wide.
- Priority: fall beats long/repeat on the same edge (release wins; no long_pulse or repeat_pulse emitted).
- Mutual exclusion: at most one of press/long/repeat asserted in any cycle; short_pulse only together with release_pulse.
- cnt never exceeds max(LONG_CYCLES, REPEAT_CYCLES)-1; no wrap-around possible given CNT_W rule.
- Reset asserted mid-press: immediate return to reset values, no pulses. If level is still 1 after reset release, first edge sees rise (level_q = 0) and emits press_pulse; this is required behaviour.

## Timing
- Edge k = first clock edge sampling level = 1 after a 0. press_pulse high for the cycle after edge k.
- long_pulse high for the cycle after edge k+LONG_CYCLES-1, provided level = 1 at edges k..k+LONG_CYCLES-1.
- repeat_pulse m (m ≥ 1) high for the cycle after edge k+LONG_CYCLES-1+m·REPEAT_CYCLES.
- release_pulse / short_pulse high for the cycle after the first edge sampling level = 0; latency 1 cycle.
- held follows level with 1-cycle latency.
- Minimum press (level = 1 for exactly one edge): press_pulse, then short_pulse+release_pulse on the next cycle.

## Test plan
- LONG=8, REPEAT=3: level high 4 cycles then low -> press_pulse at cycle 1, short_pulse+release_pulse 1 cycle after first low sample; no long_pulse.
- LONG=8, REPEAT=3: hold 20 cycles -> press at cycle 1, long_pulse at cycle 8, repeat_pulse at cycles 11, 14, 17, 20; release_pulse without short_pulse on drop.
- Release on the exact edge where cnt == LONG_CYCLES-1 -> short_pulse+release_pulse, no long_pulse.
- REPEAT_EN=0, hold 30 cycles -> exactly one press and one long_pulse, zero repeat_pulse.
- Assert rst mid-LONG with level held 1, deassert -> all outputs 0 during reset; press_pulse one cycle after first post-reset edge; long_pulse again after LONG_CYCLES.
- Single-cycle level pulse, and back-to-back presses separated by one low cycle -> each press yields press then short+release; pulses always one cycle wide, never overlapping illegally.
